// File: rtl/regfile_pkg.sv
// Shared sizing helpers for the scoreboarded register file.
// RF_SLICE picks element i of width w out of a flat packed bus.
`ifndef RF_SLICE
`define RF_SLICE(v, i, w) v[(i)*(w) +: (w)]
`endif

package regfile_pkg;
  localparam int PC_REG_DEF = 15;
  localparam int PEND_W_DEF = 2;

  typedef logic [PEND_W_DEF-1:0] pend_cnt_t;

  function automatic int addr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/pend_counter.sv
// Outstanding-write counter for one register: issues add, retires subtract, floor at 0.
// With REGFILE_BYPASS_EN, nonzero already discounts this cycle's retires.
module pend_counter #(
  parameter int W  = 2,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] inc,
  input  logic [IW-1:0] dec,
  input  logic          accept,
  output logic [W-1:0]  count,
  output logic          nonzero,
  output logic          would_overflow,
  output logic          underflow
);
  localparam int EW = W + IW + 1;
  localparam logic [EW-1:0] MAXV = EW'((1 << W) - 1);

  logic [EW-1:0] up_all;
  logic [EW-1:0] up_eff;
  logic [EW-1:0] dec_x;

  always_comb begin
    dec_x          = EW'(dec);
    up_all         = EW'(count) + EW'(inc);
    up_eff         = accept ? up_all : EW'(count);
    // Overflow is judged on the requested issues so the top can veto all of them.
    would_overflow = up_all > (dec_x + MAXV);
    underflow      = up_eff < dec_x;
`ifdef REGFILE_BYPASS_EN
    nonzero        = EW'(count) > dec_x;
`else
    nonzero        = count != '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset)          count <= '0;
    else if (underflow) count <= '0;
    else                count <= W'(up_eff - dec_x);
  end
endmodule

// File: rtl/scoreboard_regfile.sv
// NRD-read / NWR-write register file with PC override and per-register pending-write scoreboard.
// Optional macro REGFILE_BYPASS_EN: write-first read bypass and retire-aware busy flags.
module scoreboard_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG   = 16,
  parameter int NRD    = 3,
  parameter int NWR    = 2,
  parameter int PEND_W = PEND_W_DEF,
  parameter int PC_REG = PC_REG_DEF,
  localparam int AW    = addr_w(NREG)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRD*AW-1:0]     ra,
  output logic [NRD*DATA_W-1:0] rd,
  output logic [NRD-1:0]        rd_busy,
  input  logic [DATA_W-1:0]     pc_in,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*AW-1:0]     wa,
  input  logic [NWR*DATA_W-1:0] wd,
  input  logic [NWR-1:0]        iss_en,
  input  logic [NWR*AW-1:0]     iss_wa,
  output logic                  iss_rdy,
  output logic                  err_underflow
);
  localparam int IW = $clog2(NWR + 1);
  localparam logic [AW-1:0] PC_A = AW'(PC_REG);

  logic [DATA_W-1:0] regs [NREG];
  logic [IW-1:0]     inc  [NREG];
  logic [IW-1:0]     dec  [NREG];
  logic [PEND_W-1:0] pend [NREG];
  logic [NREG-1:0]   nz, ovf, unf;
  logic [AW-1:0]     a    [NRD];
  logic [DATA_W-1:0] v    [NRD];

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      inc[r] = '0;
      dec[r] = '0;
      for (int k = 0; k < NWR; k++) begin
        if (iss_en[k] && `RF_SLICE(iss_wa, k, AW) == AW'(r)) inc[r] = inc[r] + IW'(1);
        if (we[k] && `RF_SLICE(wa, k, AW) == AW'(r))         dec[r] = dec[r] + IW'(1);
      end
    end
  end

  assign iss_rdy = ~|ovf;

  for (genvar r = 0; r < NREG; r++) begin : g_cnt
    pend_counter #(.W(PEND_W), .IW(IW)) u_cnt (
      .clk           (clk),
      .reset         (reset),
      .inc           (inc[r]),
      .dec           (dec[r]),
      .accept        (iss_rdy),
      .count         (pend[r]),
      .nonzero       (nz[r]),
      .would_overflow(ovf[r]),
      .underflow     (unf[r])
    );
  end

  // Later ports are written last, so the highest index wins on address conflicts.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      for (int k = 0; k < NWR; k++)
        if (we[k] && `RF_SLICE(wa, k, AW) != PC_A)
          regs[`RF_SLICE(wa, k, AW)] <= `RF_SLICE(wd, k, DATA_W);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)     err_underflow <= 1'b0;
    else if (|unf) err_underflow <= 1'b1;
  end

  always_comb begin
    rd      = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      a[i] = `RF_SLICE(ra, i, AW);
      v[i] = regs[a[i]];
`ifdef REGFILE_BYPASS_EN
      for (int k = 0; k < NWR; k++)
        if (we[k] && `RF_SLICE(wa, k, AW) == a[i]) v[i] = `RF_SLICE(wd, k, DATA_W);
`endif
      if (a[i] == PC_A) v[i] = pc_in;
      `RF_SLICE(rd, i, DATA_W) = v[i];
      rd_busy[i] = (a[i] != PC_A) && (pend[a[i]] != '0) && nz[a[i]];
    end
  end
endmodule

// File: tb/tb_scoreboard_regfile.sv
// Scoreboard-driven bench for scoreboard_regfile; expectations queued at drive time.
module tb_scoreboard_regfile;
  localparam int DW = 32, AW = 4, NRD = 3, NWR = 2;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NRD*AW-1:0]     ra;
  logic [NRD*DW-1:0]     rd;
  logic [NRD-1:0]        rd_busy;
  logic [DW-1:0]         pc_in;
  logic [NWR-1:0]        we;
  logic [NWR*AW-1:0]     wa;
  logic [NWR*DW-1:0]     wd;
  logic [NWR-1:0]        iss_en;
  logic [NWR*AW-1:0]     iss_wa;
  logic                  iss_rdy;
  logic                  err_underflow;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  scoreboard_regfile dut (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd), .rd_busy(rd_busy), .pc_in(pc_in),
    .we(we), .wa(wa), .wd(wd), .iss_en(iss_en), .iss_wa(iss_wa),
    .iss_rdy(iss_rdy), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = '0; wa = '0; wd = '0; iss_en = '0; iss_wa = '0;
  endtask

  task automatic set_ra(input int i, input logic [AW-1:0] adr);
    ra[i*AW +: AW] = adr;
  endtask

  task automatic drv_wr(input int k, input logic [AW-1:0] adr, input logic [DW-1:0] d);
    we[k] = 1'b1; wa[k*AW +: AW] = adr; wd[k*DW +: DW] = d;
  endtask

  task automatic drv_iss(input int k, input logic [AW-1:0] adr);
    iss_en[k] = 1'b1; iss_wa[k*AW +: AW] = adr;
  endtask

  task automatic test_reset();
    reset = 1'b1; ra = '0; pc_in = '0; idle();
    we = 2'b11; wa = {4'd1, 4'd2}; wd = {32'hAAAA_0001, 32'hBBBB_0002};
    drv_iss(0, 4'd4); drv_iss(1, 4'd4);
    next(); next();
    reset = 1'b0; idle(); set_ra(0, 4'd1);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h1); exp_q.push_back(32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (rd[31:0] !== e) begin failures++; $display("FAIL reset_rd got=%h exp=%h", rd[31:0], e); end
    e = exp_q.pop_front(); checks++;
    if (32'(rd_busy) !== e) begin failures++; $display("FAIL reset_busy got=%h exp=%h", rd_busy, e); end
    e = exp_q.pop_front(); checks++;
    if (32'(iss_rdy) !== e) begin failures++; $display("FAIL reset_iss_rdy got=%b exp=%h", iss_rdy, e); end
    e = exp_q.pop_front(); checks++;
    if (32'(err_underflow) !== e) begin failures++; $display("FAIL reset_err got=%b exp=%h", err_underflow, e); end
  endtask

  task automatic test_write_bypass();
    next(); idle(); drv_iss(0, 4'd3); set_ra(0, 4'd3);
    next(); idle(); drv_wr(0, 4'd3, 32'hDEADBEEF);
    exp_q.push_back(BYP ? 32'hDEADBEEF : 32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (rd[31:0] !== e) begin failures++; $display("FAIL wr_same_cycle got=%h exp=%h", rd[31:0], e); end
    next(); idle(); exp_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (rd[31:0] !== e) begin failures++; $display("FAIL wr_next_cycle got=%h exp=%h", rd[31:0], e); end
  endtask

  task automatic test_conflict();
    next(); idle(); drv_iss(0, 4'd5); drv_iss(1, 4'd5); set_ra(0, 4'd5);
    next(); idle(); drv_wr(0, 4'd5, 32'h11); drv_wr(1, 4'd5, 32'h22);
    exp_q.push_back(BYP ? 32'h22 : 32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (rd[31:0] !== e) begin failures++; $display("FAIL conflict_same got=%h exp=%h", rd[31:0], e); end
    next(); idle(); exp_q.push_back(32'h22);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (rd[31:0] !== e) begin failures++; $display("FAIL conflict_next got=%h exp=%h", rd[31:0], e); end
  endtask

  task automatic test_pc_override();
    next(); idle(); drv_iss(0, 4'd15); pc_in = 32'h108; set_ra(1, 4'd15);
    exp_q.push_back(32'h108);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (rd[63:32] !== e) begin failures++; $display("FAIL pc_issue got=%h exp=%h", rd[63:32], e); end
    next(); idle(); drv_wr(0, 4'd15, 32'hFFFF);
    exp_q.push_back(32'h108); exp_q.push_back(32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (rd[63:32] !== e) begin failures++; $display("FAIL pc_write got=%h exp=%h", rd[63:32], e); end
    e = exp_q.pop_front(); checks++;
    if (32'(rd_busy[1]) !== e) begin failures++; $display("FAIL pc_busy got=%b exp=%h", rd_busy[1], e); end
    next(); idle(); exp_q.push_back(32'h108); exp_q.push_back(32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (rd[63:32] !== e) begin failures++; $display("FAIL pc_after got=%h exp=%h", rd[63:32], e); end
    e = exp_q.pop_front(); checks++;
    if (32'(err_underflow) !== e) begin failures++; $display("FAIL pc_no_underflow got=%b exp=%h", err_underflow, e); end
  endtask

  task automatic test_scoreboard();
    // Each row: iss_en, iss_wa1, we, expected iss_rdy, expected busy on reg 4.
    logic [1:0] t_iss [6] = '{2'b01, 2'b11, 2'b11, 2'b01, 2'b00, 2'b00};
    logic [3:0] t_wa1 [6] = '{4'd4, 4'd4, 4'd6, 4'd4, 4'd4, 4'd4};
    logic [1:0] t_we  [6] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 2'b01};
    logic       t_rdy [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       t_bsy [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, !BYP};
    set_ra(2, 4'd4);
    for (int c = 0; c < 6; c++) begin
      next(); idle();
      if (t_iss[c][0]) drv_iss(0, 4'd4);
      if (t_iss[c][1]) drv_iss(1, t_wa1[c]);
      if (t_we[c][0]) drv_wr(0, 4'd4, 32'hAA);
      if (t_we[c][1]) drv_wr(1, 4'd4, 32'hBB);
      exp_q.push_back(32'(t_rdy[c])); exp_q.push_back(32'(t_bsy[c]));
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (32'(iss_rdy) !== e) begin failures++; $display("FAIL sb_iss_rdy cyc=%0d got=%b exp=%h", c, iss_rdy, e); end
      e = exp_q.pop_front(); checks++;
      if (32'(rd_busy[2]) !== e) begin failures++; $display("FAIL sb_busy cyc=%0d got=%b exp=%h", c, rd_busy[2], e); end
    end
    next(); idle(); set_ra(0, 4'd6);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (32'(rd_busy[2]) !== e) begin failures++; $display("FAIL sb_drained got=%b exp=%h", rd_busy[2], e); end
    e = exp_q.pop_front(); checks++;
    if (32'(rd_busy[0]) !== e) begin failures++; $display("FAIL sb_rejected_issue got=%b exp=%h", rd_busy[0], e); end
    e = exp_q.pop_front(); checks++;
    if (32'(err_underflow) !== e) begin failures++; $display("FAIL sb_no_underflow got=%b exp=%h", err_underflow, e); end
  endtask

  task automatic test_underflow();
    next(); idle(); drv_wr(0, 4'd7, 32'h5); set_ra(0, 4'd7);
    exp_q.push_back(32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (32'(rd_busy[0]) !== e) begin failures++; $display("FAIL uf_busy got=%b exp=%h", rd_busy[0], e); end
    next(); idle(); exp_q.push_back(32'h1);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (32'(err_underflow) !== e) begin failures++; $display("FAIL uf_set got=%b exp=%h", err_underflow, e); end
    next(); idle(); drv_iss(0, 4'd7); exp_q.push_back(32'h1); exp_q.push_back(32'h1);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (32'(err_underflow) !== e) begin failures++; $display("FAIL uf_sticky got=%b exp=%h", err_underflow, e); end
    e = exp_q.pop_front(); checks++;
    if (32'(iss_rdy) !== e) begin failures++; $display("FAIL uf_iss_rdy got=%b exp=%h", iss_rdy, e); end
    next(); idle(); drv_wr(0, 4'd7, 32'h6);
    next(); idle(); exp_q.push_back(32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (32'(rd_busy[0]) !== e) begin failures++; $display("FAIL uf_count_floor got=%b exp=%h", rd_busy[0], e); end
    next(); reset = 1'b1; idle();
    next(); reset = 1'b0; set_ra(0, 4'd3);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (32'(err_underflow) !== e) begin failures++; $display("FAIL uf_cleared got=%b exp=%h", err_underflow, e); end
    e = exp_q.pop_front(); checks++;
    if (rd[31:0] !== e) begin failures++; $display("FAIL reset_clears_reg got=%h exp=%h", rd[31:0], e); end
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_conflict();
    test_pc_override();
    test_scoreboard();
    test_underflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
